nfc_flash_if: RTL and testbench

// NAND-flash bus sequencer inside the NFC, between the SFR/command engine and the external

---
 rtl/nfc_flash_if.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_nfc_flash_if.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_flash_if.sv
// NAND-flash pin sequencer: drives CLE/ALE/WE#/RE# cycles for command, address and data
// phases; write data is pulled from memory, read data pushed to memory with a ready handshake.
module nfc_flash_if #(
  parameter int DAT_WID = 8,
  parameter int SFR_WID = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DAT_WID-1:0] nf_din,
  output logic [DAT_WID-1:0] nf_dout,
  output logic               nf_dir,
  output logic               nf_cle,
  output logic               nf_ale,
  output logic               nf_web,
  output logic               nf_reb,
  input  logic               nfc_dat_inv,
  input  logic               nfc_dat_dir,
  input  logic               nfc_cmd_en,
  input  logic [SFR_WID-1:0] nfc_if_cmd,
  input  logic               nfc_addr_en,
  input  logic [31:0]        nfc_col_addr,
  input  logic [31:0]        nfc_row_addr,
  input  logic [5:0]         nfc_addr_cnt,
  input  logic               nfc_dat_en,
  input  logic [13:0]        nfc_dat_cnt,
  input  logic [SFR_WID-1:0] nfc_tconf,
  input  logic [1:0]         nfc_mode,
  output logic               nfif_cmd_done,
  output logic               nfif_addr_done,
  output logic               nfif_dat_done,
  output logic               nfif_dat_rdy,
  input  logic               mem_if_wr,
  input  logic [DAT_WID-1:0] mem_if_din,
  output logic               nfif_data_wr,
  output logic [DAT_WID-1:0] nfif_data_out,
  input  logic               nfif_wr_rdy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] WREQ  = 3'd3;
  localparam logic [2:0] WCYC  = 3'd4;
  localparam logic [2:0] RCYC  = 3'd5;
  localparam logic [2:0] RPUSH = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  function automatic logic [2:0] clamp4(input logic [2:0] c);
    return (c > 3'd4) ? 3'd4 : c;
  endfunction

  function automatic logic [7:0] addr_byte(input logic [31:0] col, input logic [31:0] row,
                                           input logic [2:0] ncol, input logic [2:0] idx);
    logic [2:0]  k;
    logic [31:0] w;
    if (idx < ncol) begin
      k = idx;
      w = col;
    end else begin
      k = idx - ncol;
      w = row;
    end
    w = w >> {k, 3'b000};
    return w[7:0];
  endfunction

  logic [2:0]         state;
  logic               hi, busy, late, dat_en_q;
  logic [2:0]         tcnt, tl_q, th_q, idx, ncol_q;
  logic [3:0]         ntot_q;
  logic [31:0]        col_q, row_q;
  logic [13:0]        words;
  logic               edo_q, inv_q;
  logic [DAT_WID-1:0] cap;

  logic [2:0]         ncol_in, nrow_in;
  logic [3:0]         ntot_in;
  logic               dat_rise, tdone, last_byte;
  logic [DAT_WID-1:0] inv_mask, rd_word;
  logic               unused_cfg;

  assign ncol_in    = clamp4(nfc_addr_cnt[2:0]);
  assign nrow_in    = clamp4(nfc_addr_cnt[5:3]);
  assign ntot_in    = {1'b0, ncol_in} + {1'b0, nrow_in};
  assign dat_rise   = nfc_dat_en & ~dat_en_q;
  assign tdone      = (tcnt == 3'd0);
  assign last_byte  = (({1'b0, idx} + 4'd1) == ntot_q);
  assign inv_mask   = {DAT_WID{inv_q}};
  assign rd_word    = nf_din ^ inv_mask;
  // Only async SDR exists, so the bus mode is accepted and ignored.
  assign unused_cfg = ^{nfc_mode, nfc_tconf[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      nf_dout        <= '0;
      nf_dir         <= 1'b0;
      nf_cle         <= 1'b0;
      nf_ale         <= 1'b0;
      nf_web         <= 1'b1;
      nf_reb         <= 1'b1;
      nfif_cmd_done  <= 1'b0;
      nfif_addr_done <= 1'b0;
      nfif_dat_done  <= 1'b0;
      nfif_dat_rdy   <= 1'b0;
      nfif_data_wr   <= 1'b0;
      nfif_data_out  <= '0;
      hi             <= 1'b0;
      busy           <= 1'b0;
      late           <= 1'b0;
      dat_en_q       <= 1'b0;
      tcnt           <= '0;
      tl_q           <= '0;
      th_q           <= '0;
      idx            <= '0;
      ncol_q         <= '0;
      ntot_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      words          <= '0;
      edo_q          <= 1'b0;
      inv_q          <= 1'b0;
      cap            <= '0;
    end else begin
      nfif_cmd_done  <= 1'b0;
      nfif_addr_done <= 1'b0;
      nfif_dat_done  <= 1'b0;
      nfif_data_wr   <= 1'b0;
      dat_en_q       <= nfc_dat_en;
      case (state)
        IDLE: begin
          tl_q <= nfc_tconf[2:0];
          th_q <= nfc_tconf[6:4];
          hi   <= 1'b0;
          tcnt <= nfc_tconf[2:0];
          if (nfc_cmd_en) begin
            nf_dout <= DAT_WID'(nfc_if_cmd);
            nf_dir  <= 1'b1;
            nf_cle  <= 1'b1;
            nf_web  <= 1'b0;
            state   <= CMD;
          end else if (nfc_addr_en) begin
            col_q  <= nfc_col_addr;
            row_q  <= nfc_row_addr;
            ncol_q <= ncol_in;
            ntot_q <= ntot_in;
            idx    <= '0;
            if (ntot_in == 4'd0) begin
              nfif_addr_done <= 1'b1;
              state          <= DONE;
            end else begin
              nf_dout <= DAT_WID'(addr_byte(nfc_col_addr, nfc_row_addr, ncol_in, 3'd0));
              nf_dir  <= 1'b1;
              nf_ale  <= 1'b1;
              nf_web  <= 1'b0;
              state   <= ADDR;
            end
          end else if (dat_rise) begin
            words <= nfc_dat_cnt;
            inv_q <= nfc_dat_inv;
            edo_q <= nfc_tconf[7];
            busy  <= 1'b0;
            if (nfc_dat_cnt == 14'd0) begin
              nfif_dat_done <= 1'b1;
              state         <= DONE;
            end else if (nfc_dat_dir) begin
              nf_dir       <= 1'b1;
              nfif_dat_rdy <= 1'b1;
              state        <= WREQ;
            end else begin
              state <= RCYC;
            end
          end
        end
        CMD: begin
          if (!tdone) begin
            tcnt <= tcnt - 3'd1;
          end else if (!hi) begin
            nf_web <= 1'b1;
            hi     <= 1'b1;
            tcnt   <= th_q;
          end else begin
            nf_cle        <= 1'b0;
            nf_dir        <= 1'b0;
            nfif_cmd_done <= 1'b1;
            state         <= DONE;
          end
        end
        ADDR: begin
          if (!tdone) begin
            tcnt <= tcnt - 3'd1;
          end else if (!hi) begin
            nf_web <= 1'b1;
            hi     <= 1'b1;
            tcnt   <= th_q;
          end else if (last_byte) begin
            nf_ale         <= 1'b0;
            nf_dir         <= 1'b0;
            nfif_addr_done <= 1'b1;
            state          <= DONE;
          end else begin
            idx     <= idx + 3'd1;
            nf_dout <= DAT_WID'(addr_byte(col_q, row_q, ncol_q, idx + 3'd1));
            nf_web  <= 1'b0;
            hi      <= 1'b0;
            tcnt    <= tl_q;
          end
        end
        WREQ: begin
          if (mem_if_wr) begin
            nf_dout      <= mem_if_din ^ inv_mask;
            nfif_dat_rdy <= 1'b0;
            nf_web       <= 1'b0;
            hi           <= 1'b0;
            tcnt         <= tl_q;
            state        <= WCYC;
          end
        end
        WCYC: begin
          if (!tdone) begin
            tcnt <= tcnt - 3'd1;
          end else if (!hi) begin
            nf_web <= 1'b1;
            hi     <= 1'b1;
            tcnt   <= th_q;
          end else begin
            words <= words - 14'd1;
            if (words == 14'd1) begin
              nf_dir        <= 1'b0;
              nfif_dat_done <= 1'b1;
              state         <= DONE;
            end else begin
              nfif_dat_rdy <= 1'b1;
              state        <= WREQ;
            end
          end
        end
        RCYC: begin
          if (!busy) begin
            if (nfif_wr_rdy) begin
              nf_reb <= 1'b0;
              busy   <= 1'b1;
              hi     <= 1'b0;
              tcnt   <= tl_q;
            end
          end else if (!hi) begin
            if (tdone) begin
              nf_reb <= 1'b1;
              hi     <= 1'b1;
              tcnt   <= th_q;
              late   <= edo_q;
              if (!edo_q) cap <= rd_word;
            end else begin
              tcnt <= tcnt - 3'd1;
            end
          end else begin
            // Late capture lands on the first high clk; with a 1-clk high pulse that is also the push clk.
            if (late) begin
              cap  <= rd_word;
              late <= 1'b0;
            end
            if (tdone) begin
              nfif_data_out <= late ? rd_word : cap;
              nfif_data_wr  <= 1'b1;
              busy          <= 1'b0;
              state         <= RPUSH;
            end else begin
              tcnt <= tcnt - 3'd1;
            end
          end
        end
        RPUSH: begin
          words <= words - 14'd1;
          if (words == 14'd1) begin
            nfif_dat_done <= 1'b1;
            state         <= DONE;
          end else begin
            state <= RCYC;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_flash_if.sv
// Randomized bench for nfc_flash_if: a pin monitor, a NAND data model and a memory-side
// responder feed per-scenario checks against expectations computed from the bus rules.
module tb_nfc_flash_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  nf_din, nf_dout;
  logic        nf_dir, nf_cle, nf_ale, nf_web, nf_reb;
  logic        nfc_dat_inv, nfc_dat_dir, nfc_cmd_en, nfc_addr_en, nfc_dat_en;
  logic [7:0]  nfc_if_cmd, nfc_tconf;
  logic [31:0] nfc_col_addr, nfc_row_addr;
  logic [5:0]  nfc_addr_cnt;
  logic [13:0] nfc_dat_cnt;
  logic [1:0]  nfc_mode;
  logic        nfif_cmd_done, nfif_addr_done, nfif_dat_done, nfif_dat_rdy;
  logic        mem_if_wr, nfif_data_wr, nfif_wr_rdy;
  logic [7:0]  mem_if_din, nfif_data_out;

  always #5 clk = ~clk;

  nfc_flash_if #(.DAT_WID(8), .SFR_WID(8)) dut (
    .clk(clk), .rst(rst), .nf_din(nf_din), .nf_dout(nf_dout), .nf_dir(nf_dir),
    .nf_cle(nf_cle), .nf_ale(nf_ale), .nf_web(nf_web), .nf_reb(nf_reb),
    .nfc_dat_inv(nfc_dat_inv), .nfc_dat_dir(nfc_dat_dir), .nfc_cmd_en(nfc_cmd_en),
    .nfc_if_cmd(nfc_if_cmd), .nfc_addr_en(nfc_addr_en), .nfc_col_addr(nfc_col_addr),
    .nfc_row_addr(nfc_row_addr), .nfc_addr_cnt(nfc_addr_cnt), .nfc_dat_en(nfc_dat_en),
    .nfc_dat_cnt(nfc_dat_cnt), .nfc_tconf(nfc_tconf), .nfc_mode(nfc_mode),
    .nfif_cmd_done(nfif_cmd_done), .nfif_addr_done(nfif_addr_done),
    .nfif_dat_done(nfif_dat_done), .nfif_dat_rdy(nfif_dat_rdy), .mem_if_wr(mem_if_wr),
    .mem_if_din(mem_if_din), .nfif_data_wr(nfif_data_wr), .nfif_data_out(nfif_data_out),
    .nfif_wr_rdy(nfif_wr_rdy)
  );

  typedef struct {
    logic [7:0] d;
    logic       cle, ale, dir;
    int         len, gap;
  } pulse_t;

  pulse_t     wq[$];
  int         rq_len[$];
  logic [7:0] sq[$];
  logic [7:0] nand_q[$];
  pulse_t     cur;
  int         wlen = 0, whigh = 0, rlen = 0;
  int         cmd_n = 0, addr_n = 0, dat_n = 0, stall_err = 0, dir_err = 0;
  logic       rdy_prev = 1'b0;
  bit         nand_on = 0, nand_late = 0, rdy_auto = 0;
  int         passed = 0, total = 0;

  // Pin monitor: web/reb pulse records, done pulses, read strobes, stall and direction violations.
  always @(negedge clk) begin
    if (rst) begin
      wlen = 0; whigh = 0; rlen = 0;
    end else begin
      if (!nf_web) begin
        if (wlen == 0) begin
          cur.d = nf_dout; cur.cle = nf_cle; cur.ale = nf_ale; cur.dir = nf_dir; cur.gap = whigh;
        end
        wlen++;
      end else begin
        if (wlen > 0) begin
          cur.len = wlen; wq.push_back(cur); wlen = 0; whigh = 0;
        end
        whigh++;
      end
      if (!nf_reb) begin
        if (rlen == 0 && !rdy_prev) stall_err++;
        if (nf_dir) dir_err++;
        rlen++;
      end else if (rlen > 0) begin
        rq_len.push_back(rlen); rlen = 0;
      end
      cmd_n  += int'(nfif_cmd_done);
      addr_n += int'(nfif_addr_done);
      dat_n  += int'(nfif_dat_done);
      if (nfif_data_wr) sq.push_back(nfif_data_out);
    end
    rdy_prev = nfif_wr_rdy;
  end

  // NAND model: real data is valid only while reb is low, or only after reb rises in EDO mode.
  initial forever begin
    @(negedge nf_reb);
    if (nand_on) begin
      #1;
      if (nand_late) nf_din = 8'($urandom);
      else nf_din = (nand_q.size() > 0) ? nand_q.pop_front() : 8'($urandom);
    end
  end
  initial forever begin
    @(posedge nf_reb);
    if (nand_on) begin
      #1;
      if (!nand_late) nf_din = 8'($urandom);
      else nf_din = (nand_q.size() > 0) ? nand_q.pop_front() : 8'($urandom);
    end
  end

  // Memory side of reads: drops ready 2 clk after each strobe for a random stretch.
  initial forever begin
    @(negedge clk);
    if (rdy_auto && nfif_data_wr) begin
      repeat (2) @(posedge clk);
      #1 nfif_wr_rdy = 1'b0;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1 nfif_wr_rdy = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    wq.delete(); rq_len.delete(); sq.delete();
    cmd_n = 0; addr_n = 0; dat_n = 0; stall_err = 0; dir_err = 0;
  endtask

  task automatic wait_done(input int which, input int budget, output bit ok);
    int k;
    k = 0;
    while (k < budget && ((which == 0 && cmd_n == 0) || (which == 1 && addr_n == 0) ||
                          (which == 2 && dat_n == 0))) begin
      @(negedge clk);
      k++;
    end
    ok = (which == 0) ? (cmd_n > 0) : (which == 1) ? (addr_n > 0) : (dat_n > 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    total++;
    if ({nf_web, nf_reb, nf_cle, nf_ale, nf_dir} !== 5'b11000)
      $display("FAIL reset_pins: got %b expected 11000", {nf_web, nf_reb, nf_cle, nf_ale, nf_dir});
    else passed++;
    rst = 1'b0;
    clear_mon;
    repeat (6) tick;
    total++;
    if ({nf_web, nf_reb, nf_cle, nf_ale, nf_dir, nfif_dat_rdy, nfif_data_wr} !== 7'b1100000 ||
        nf_dout !== 8'h00 || nfif_data_out !== 8'h00)
      $display("FAIL idle_pins: got %b dout=%h data_out=%h expected 1100000/00/00",
               {nf_web, nf_reb, nf_cle, nf_ale, nf_dir, nfif_dat_rdy, nfif_data_wr}, nf_dout, nfif_data_out);
    else passed++;
    total++;
    if (cmd_n + addr_n + dat_n + wq.size() + rq_len.size() !== 0)
      $display("FAIL idle_activity: got %0d events expected 0", cmd_n + addr_n + dat_n + wq.size() + rq_len.size());
    else passed++;
  endtask

  task automatic test_cmd(input logic [7:0] cmd, input logic [7:0] tc);
    bit ok;
    int tl;
    tl = int'(tc[2:0]) + 1;
    clear_mon;
    nfc_tconf = tc; nfc_if_cmd = cmd; nfc_cmd_en = 1'b1;
    tick;
    nfc_cmd_en = 1'b0;
    wait_done(0, 40, ok);
    repeat (3) tick;
    total++;
    if (ok !== 1'b1) $display("FAIL cmd_done_timeout: got 0 expected 1"); else passed++;
    total++;
    if (wq.size() !== 1) $display("FAIL cmd_pulses: got %0d expected 1", wq.size()); else passed++;
    if (wq.size() > 0) begin
      total++;
      if ({wq[0].d, wq[0].cle, wq[0].ale, wq[0].dir} !== {cmd, 3'b101} || wq[0].len != tl)
        $display("FAIL cmd_cycle: got d=%h cle=%b ale=%b dir=%b len=%0d expected d=%h 1/0/1 len=%0d",
                 wq[0].d, wq[0].cle, wq[0].ale, wq[0].dir, wq[0].len, cmd, tl);
      else passed++;
    end
    total++;
    if (cmd_n !== 1 || {nf_cle, nf_dir, nf_web} !== 3'b001)
      $display("FAIL cmd_end: got done=%0d cle/dir/web=%b expected 1 and 001", cmd_n, {nf_cle, nf_dir, nf_web});
    else passed++;
  endtask

  task automatic test_addr(input logic [5:0] cnt, input logic [31:0] col, input logic [31:0] row,
                           input logic [7:0] tc);
    logic [7:0] exp[$];
    int nc, nr, tl, th;
    bit ok;
    nc = (cnt[2:0] > 3'd4) ? 4 : int'(cnt[2:0]);
    nr = (cnt[5:3] > 3'd4) ? 4 : int'(cnt[5:3]);
    for (int i = 0; i < nc; i++) exp.push_back(8'((col >> (8 * i)) & 32'hFF));
    for (int i = 0; i < nr; i++) exp.push_back(8'((row >> (8 * i)) & 32'hFF));
    tl = int'(tc[2:0]) + 1;
    th = int'(tc[6:4]) + 1;
    clear_mon;
    nfc_tconf = tc; nfc_addr_cnt = cnt; nfc_col_addr = col; nfc_row_addr = row; nfc_addr_en = 1'b1;
    tick;
    nfc_addr_en = 1'b0;
    wait_done(1, 300, ok);
    repeat (3) tick;
    total++;
    if (ok !== 1'b1) $display("FAIL addr_done_timeout: got 0 expected 1"); else passed++;
    total++;
    if (wq.size() !== exp.size())
      $display("FAIL addr_pulses: got %0d expected %0d", wq.size(), exp.size());
    else passed++;
    for (int i = 0; i < wq.size() && i < exp.size(); i++) begin
      total++;
      if ({wq[i].d, wq[i].cle, wq[i].ale, wq[i].dir} !== {exp[i], 3'b011} || wq[i].len != tl)
        $display("FAIL addr_byte%0d: got d=%h cle=%b ale=%b dir=%b len=%0d expected d=%h 0/1/1 len=%0d",
                 i, wq[i].d, wq[i].cle, wq[i].ale, wq[i].dir, wq[i].len, exp[i], tl);
      else passed++;
      if (i > 0) begin
        total++;
        if (wq[i].gap != th) $display("FAIL addr_high%0d: got %0d expected %0d", i, wq[i].gap, th);
        else passed++;
      end
    end
    total++;
    if (addr_n !== 1 || {nf_ale, nf_dir} !== 2'b00)
      $display("FAIL addr_end: got done=%0d ale/dir=%b expected 1 and 00", addr_n, {nf_ale, nf_dir});
    else passed++;
  endtask

  task automatic test_write(input int n, input logic [7:0] tc, input logic inv, input bit seq);
    logic [7:0] vals[$];
    logic [7:0] v;
    bit ok;
    int tl, to, k;
    tl = int'(tc[2:0]) + 1;
    to = 0;
    clear_mon;
    nfc_tconf = tc; nfc_dat_inv = inv; nfc_dat_dir = 1'b1; nfc_dat_cnt = 14'(n); nfc_dat_en = 1'b1;
    tick;
    for (int w = 0; w < n; w++) begin
      k = 0;
      @(negedge clk);
      while (!nfif_dat_rdy && k < 60) begin
        @(negedge clk);
        k++;
      end
      if (!nfif_dat_rdy) begin
        to++;
        break;
      end
      v = seq ? 8'(w + 1) : 8'($urandom);
      vals.push_back(v);
      tick;
      mem_if_wr = 1'b1; mem_if_din = v;
      tick;
      mem_if_wr = 1'b0;
    end
    wait_done(2, 40, ok);
    repeat (6) tick;
    total++;
    if (ok !== 1'b1 || to !== 0) $display("FAIL wr_timeout: got done=%0d rdy_timeouts=%0d expected 1 and 0", ok, to);
    else passed++;
    total++;
    if (wq.size() !== n) $display("FAIL wr_pulses: got %0d expected %0d", wq.size(), n); else passed++;
    for (int i = 0; i < wq.size() && i < vals.size(); i++) begin
      total++;
      if ({wq[i].d, wq[i].cle, wq[i].ale, wq[i].dir} !== {vals[i] ^ {8{inv}}, 3'b001} || wq[i].len != tl)
        $display("FAIL wr_word%0d: got d=%h cle/ale/dir=%b%b%b len=%0d expected d=%h 001 len=%0d", i,
                 wq[i].d, wq[i].cle, wq[i].ale, wq[i].dir, wq[i].len, vals[i] ^ {8{inv}}, tl);
      else passed++;
    end
    total++;
    if (dat_n !== 1 || nf_dir !== 1'b0 || nfif_dat_rdy !== 1'b0)
      $display("FAIL wr_end: got done=%0d dir=%b rdy=%b expected 1,0,0 with dat_en held", dat_n, nf_dir, nfif_dat_rdy);
    else passed++;
    nfc_dat_en = 1'b0;
    tick;
  endtask

  task automatic test_read(input int n, input logic [7:0] tc, input logic inv);
    logic [7:0] exp[$];
    logic [7:0] v;
    bit ok;
    int tl;
    tl = int'(tc[2:0]) + 1;
    clear_mon;
    nand_q.delete();
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      exp.push_back(v);
      nand_q.push_back(v);
    end
    nand_late = tc[7]; nand_on = 1; nfif_wr_rdy = 1'b1; rdy_auto = 1;
    nfc_tconf = tc; nfc_dat_inv = inv; nfc_dat_dir = 1'b0; nfc_dat_cnt = 14'(n); nfc_dat_en = 1'b1;
    tick;
    nfc_dat_en = 1'b0;
    wait_done(2, n * 60 + 20, ok);
    repeat (3) tick;
    rdy_auto = 0;
    repeat (9) tick;
    nfif_wr_rdy = 1'b1;
    nand_on = 0;
    total++;
    if (ok !== 1'b1 || dat_n !== 1) $display("FAIL rd_done: got ok=%0d count=%0d expected 1,1", ok, dat_n);
    else passed++;
    total++;
    if (sq.size() !== n || rq_len.size() !== n)
      $display("FAIL rd_count: got strobes=%0d reb=%0d expected %0d", sq.size(), rq_len.size(), n);
    else passed++;
    for (int i = 0; i < sq.size() && i < exp.size(); i++) begin
      total++;
      if (sq[i] !== (exp[i] ^ {8{inv}}))
        $display("FAIL rd_word%0d: got %h expected %h", i, sq[i], exp[i] ^ {8{inv}});
      else passed++;
    end
    for (int i = 0; i < rq_len.size(); i++) begin
      total++;
      if (rq_len[i] != tl) $display("FAIL rd_low%0d: got %0d expected %0d", i, rq_len[i], tl);
      else passed++;
    end
    total++;
    if (stall_err !== 0 || dir_err !== 0 || wq.size() !== 0)
      $display("FAIL rd_pins: got stall=%0d dir=%0d web=%0d expected 0,0,0", stall_err, dir_err, wq.size());
    else passed++;
  endtask

  task automatic test_reset_mid_read;
    int k;
    clear_mon;
    nand_late = 0; nand_on = 1; nfif_wr_rdy = 1'b1; rdy_auto = 1;
    nfc_tconf = 8'h11; nfc_dat_inv = 1'b0; nfc_dat_dir = 1'b0; nfc_dat_cnt = 14'd20; nfc_dat_en = 1'b1;
    tick;
    nfc_dat_en = 1'b0;
    k = 0;
    while (sq.size() < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (sq.size() < 3) $display("FAIL rst_prep: got %0d strobes expected >=3", sq.size()); else passed++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({nf_web, nf_reb, nf_cle, nf_ale, nf_dir, nfif_data_wr, nfif_dat_rdy} !== 7'b1100000 ||
        nfif_data_out !== 8'h00 || nf_dout !== 8'h00)
      $display("FAIL rst_async: got %b out=%h dout=%h expected 1100000/00/00",
               {nf_web, nf_reb, nf_cle, nf_ale, nf_dir, nfif_data_wr, nfif_dat_rdy}, nfif_data_out, nf_dout);
    else passed++;
    rdy_auto = 0; nand_on = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon;
    repeat (10) tick;
    nfif_wr_rdy = 1'b1;
    total++;
    if (dat_n !== 0 || sq.size() !== 0 || rq_len.size() !== 0)
      $display("FAIL rst_abort: got done=%0d strobes=%0d reb=%0d expected 0,0,0", dat_n, sq.size(), rq_len.size());
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    nf_din = 8'h00; nfc_dat_inv = 1'b0; nfc_dat_dir = 1'b0; nfc_cmd_en = 1'b0; nfc_addr_en = 1'b0;
    nfc_dat_en = 1'b0; nfc_if_cmd = 8'h00; nfc_tconf = 8'h00; nfc_col_addr = '0; nfc_row_addr = '0;
    nfc_addr_cnt = '0; nfc_dat_cnt = '0; nfc_mode = 2'b00; mem_if_wr = 1'b0; mem_if_din = 8'h00;
    nfif_wr_rdy = 1'b0;
    test_reset;
    test_cmd(8'h70, 8'h00);
    for (int i = 0; i < 3; i++) begin
      nfc_mode = 2'($urandom);
      test_cmd(8'($urandom), 8'($urandom));
    end
    nfc_mode = 2'b00;
    test_addr(6'b011_010, 32'h00AA0302, 32'h0022CC55, 8'h00);
    test_addr(6'b111_101, 32'h44332211, 32'h88776655, 8'h21);
    test_addr(6'b000_000, 32'h12345678, 32'h9ABCDEF0, 8'h00);
    for (int i = 0; i < 3; i++) test_addr(6'($urandom), $urandom, $urandom, 8'($urandom));
    test_write(16, 8'h00, 1'b0, 1'b1);
    test_write(8, 8'($urandom) & 8'h33, 1'b1, 1'b0);
    test_write(0, 8'h00, 1'b0, 1'b0);
    test_read(16, 8'h00, 1'b0);
    test_read(16, 8'h80 | (8'($urandom) & 8'h33), 1'b1);
    test_read(8, 8'h80, 1'b0);
    test_read(0, 8'h00, 1'b0);
    test_reset_mid_read;
    test_cmd(8'hFF, 8'h12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
